// File: rtl/full_adder.sv
// Existing 1-bit full adder cell, reused unmodified by sequential consumers
// such as serial_adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a carry flop, operands
// shifted through LSB-first, registered {cout,sum} with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] res_shift;

  full_adder u_fa (
    .A    (a_sr_q[0]),
    .B    (b_sr_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // New sum bit enters at the MSB; the shift form also covers WIDTH == 1.
  assign res_shift = WIDTH'({fa_s, res_sr_q} >> 1);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_sr_d = res_shift;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = res_shift;
          cout_d  = fa_cout;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are decoded from the next state so they leave a flop.
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH 8, 1 and 16 instances share stimulus;
// a cycle-level reference model predicts acceptance, result and done timing.
module tb_serial_adder;

  localparam int N_INST = 3;

  typedef struct packed {
    logic [31:0] res;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;

  wire  [2:0]  busy_w;
  wire  [2:0]  done_w;
  wire  [2:0]  cout_w;
  wire  [7:0]  sum8;
  wire  [0:0]  sum1;
  wire  [15:0] sum16;

  exp_t        sb_q    [N_INST][$];
  int          acc     [N_INST];
  int          idle_at [N_INST];
  int          n_ops   [N_INST];
  logic [31:0] hold    [N_INST];

  int cyc   = -1;
  bit armed = 1'b0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum8), .cout(cout_w[0])
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a[0:0]), .b(b[0:0]), .cin(cin),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum1), .cout(cout_w[1])
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum16), .cout(cout_w[2])
  );

  function automatic int wid(input int k);
    return (k == 0) ? 8 : (k == 1) ? 1 : 16;
  endfunction

  function automatic logic [31:0] obs(input int k);
    case (k)
      0:       return {23'b0, cout_w[0], sum8};
      1:       return {30'b0, cout_w[1], sum1};
      default: return {15'b0, cout_w[2], sum16};
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: an add is accepted when start is seen and the adder has
  // been free since its last done; the result is plain arithmetic on the operands.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) armed = 1'b1;
      for (int k = 0; k < N_INST; k++) begin
        if (rst) begin
          sb_q[k].delete();
          acc[k]     = -1;
          idle_at[k] = cyc + 1;
          hold[k]    = '0;
        end else if (armed && start && cyc >= idle_at[k]) begin
          automatic int          w = wid(k);
          automatic logic [31:0] m = (32'd1 << w) - 32'd1;
          automatic exp_t        e;
          e.res = ((32'(a) & m) + (32'(b) & m) + 32'(cin)) & ((32'd1 << (w + 1)) - 32'd1);
          e.due = cyc + w;
          sb_q[k].push_back(e);
          acc[k]     = cyc;
          idle_at[k] = cyc + w + 2;
          n_ops[k]++;
        end
      end
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each done.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int k = 0; k < N_INST; k++) begin
          automatic int   w        = wid(k);
          automatic logic busy_exp = (acc[k] >= 0) && (cyc >= acc[k]) && (cyc < acc[k] + w);
          automatic logic done_exp = (acc[k] >= 0) && (cyc == acc[k] + w);
          check($sformatf("w%0d_busy", w), 32'(busy_w[k]), 32'(busy_exp));
          check($sformatf("w%0d_done", w), 32'(done_w[k]), 32'(done_exp));
          check($sformatf("w%0d_busy_done_overlap", w), 32'(busy_w[k] & done_w[k]), 32'd0);
          if (done_w[k] && sb_q[k].size() > 0) begin
            automatic exp_t e = sb_q[k].pop_front();
            check($sformatf("w%0d_result", w), obs(k), e.res);
            check($sformatf("w%0d_done_edge", w), 32'(cyc), 32'(e.due));
            hold[k] = e.res;
          end else if (!done_w[k]) begin
            check($sformatf("w%0d_result_hold", w), obs(k), hold[k]);
          end
        end
      end
    end
  end

  task automatic op8(input logic [7:0] ea, input logic [7:0] eb, input logic ec,
                     input logic [8:0] eres, input string nm);
    bit seen = 1'b0;
    @(negedge clk);
    a = 16'(ea); b = 16'(eb); cin = ec; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done_w[0]) begin
        check({nm, "_sum"}, {23'b0, cout_w[0], sum8}, {23'b0, eres});
        check({nm, "_latency"}, 32'(i), 32'd8);
        seen = 1'b1;
        break;
      end
    end
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_done;
    bit  reached;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_state", {22'b0, busy_w[0], done_w[0], cout_w[0], sum8}, 32'd0);

    op8(8'h35, 8'h4A, 1'b0, 9'h07F, "basic");
    op8(8'hFF, 8'h01, 1'b0, 9'h100, "ripple_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "ripple_ff_ff_c1");

    // Start pulses 3 and 8 edges after acceptance must be ignored.
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; cin = 1'b0; start = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = (i == 2) || (i == 7);
      a = 16'h00AA; b = 16'h0055;
      if (done_w[0]) begin
        n_done++;
        check("ignored_start_sum", {23'b0, cout_w[0], sum8}, 32'h030);
        check("ignored_start_latency", 32'(i), 32'd8);
      end
    end
    check("ignored_start_done_count", 32'(n_done), 32'd1);

    // Reset four edges into SHIFT aborts the add.
    @(negedge clk);
    a = 16'h005A; b = 16'h0033; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_mid_outputs", {22'b0, busy_w[0], done_w[0], cout_w[0], sum8}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_w[0]) n_done++;
    end
    check("reset_mid_no_done", 32'(n_done), 32'd0);
    op8(8'h01, 8'h02, 1'b0, 9'h003, "after_reset");

    // Back-to-back: start held high with fresh random operands every cycle.
    for (int c = 0; c < 30000; c++) begin
      if (n_ops[0] >= 1000 && n_ops[2] >= 500) break;
      @(negedge clk);
      start = 1'b1;
      a     = 16'($urandom);
      b     = 16'($urandom);
      cin   = 1'($urandom);
    end
    reached = (n_ops[0] >= 1000) && (n_ops[2] >= 500);
    check("b2b_op_budget", 32'(reached), 32'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    for (int k = 0; k < N_INST; k++)
      check($sformatf("w%0d_scoreboard_drained", wid(k)), 32'(sb_q[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder built around one instance of the team's existing 1-bit full_adder cell plus a carry flip-flop. It accepts two operands and a carry-in on a start pulse and shifts them through the cell LSB-first, one bit per clock. It then presents the registered sum and carry-out with a one-cycle done pulse. It is the sequential consumer of full_adder and trades latency for area against a ripple adder.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range is WIDTH >= 1.

Ports:
clk  input  1  single system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
cin  input  1  carry-in; captured on the accepted start edge
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse when sum/cout update
sum  output  WIDTH  registered result; holds until the next completion
cout  output  1  registered carry-out of bit WIDTH-1; holds like sum

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry FF and bit counter all cleared. Reset wins over every other input.
- Reset mid-operation aborts the add. No done pulse is issued and sum/cout read 0.
- States: IDLE, SHIFT, DONE. State encoding is localparams inside the module.
- IDLE:
  - start=1 at an edge loads a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, at each edge:
  - full_adder(A=a_sr[0], B=b_sr[0], Cin=carry) produces S and Cout.
  - res_sr <= {S, res_sr[WIDTH-1:1]}; a_sr and b_sr shift right by one; carry<=Cout; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: sum<={S, res_sr[WIDTH-1:1]}, cout<=Cout, state goes to DONE.
- DONE: done=1 for exactly this one cycle. The next edge goes to IDLE unconditionally.
- busy=1 exactly in SHIFT. busy and done are never high together.
- Latency: if start is accepted at edge E, sum/cout update and done rises at edge E+WIDTH. The next start can be accepted at edge E+WIDTH+2 at the earliest.
- start while in SHIFT or DONE is ignored, with no queuing. Changes on a/b/cin after capture have no effect.
- sum/cout are not disturbed during SHIFT. They change only at completion or reset.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). The result is unsigned and the full-width carry is exposed.
- Counter: $clog2(WIDTH) bits, minimum 1 bit. It must not wrap before the terminal compare.
- WIDTH=1: a single SHIFT cycle, then DONE.
- done, busy, sum and cout are all driven from flops (no combinational path from inputs to outputs).

Decomposition:
- No shared package is needed. The state encoding and counter width are local to serial_adder.
- Sub-module: instantiate the existing full_adder (A, B, Cin, S, Cout) once, unmodified. The carry flip-flop, shift registers and FSM live in serial_adder.

Test Plan:
- Basic add: rst 2 cycles, then a=8'h35, b=8'h4A, cin=0, start for 1 cycle -> busy=1 for 8 cycles, then done=1 for 1 cycle with sum=8'h7F, cout=0, exactly 8 edges after the start edge.
- Carry ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Ignored start: start a=8'h10, b=8'h20. Pulse start with a=8'hAA, b=8'h55 at cycles 3 and 8 after acceptance -> result sum=8'h30, cout=0, exactly one done pulse, sum unchanged until then.
- Reset mid-op: assert rst 4 cycles into SHIFT -> next cycle busy=0, done=0, sum=0, cout=0, and no done pulse ever follows. A subsequent start with 8'h01+8'h02 -> sum=8'h03.
- Back-to-back: hold start=1 continuously with random operands for 1000 operations -> each result matches a+b+cin, done pulses spaced exactly WIDTH+2 cycles, busy/done never overlap.
- Parameter sweep: WIDTH=1 and WIDTH=16 with exhaustive (WIDTH=1) or 500 random vectors -> {cout,sum}==a+b+cin, done at start edge + WIDTH.
